// File: rtl/exe_dly_sequencer_pkg.sv
// Shared definitions for the execution delay sequencer: default widths,
// FSM state encoding and the two opcodes that produce jump requests.
package exe_dly_sequencer_pkg;

    localparam int OPR_W_DEF = 5;
    localparam int DLY_W_DEF = 8;
    localparam int PRF_W_DEF = 16;

    localparam int OPR_JMP = 16;
    localparam int OPR_JRE = 17;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETIRE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/exe_dly_sequencer_if.sv
// Decode/execute/fetch side signals of the sequencer. master is the
// environment (decoder, units, fetch); slave is the sequencer itself.
interface exe_dly_sequencer_if
    import exe_dly_sequencer_pkg::*;
#(
    parameter int OPR_W = OPR_W_DEF,
    parameter int DLY_W = DLY_W_DEF,
    parameter int PRF_W = PRF_W_DEF
);
    logic             dec_vld;
    logic             dec_rdy;
    logic [OPR_W-1:0] opr_typ;
    logic             dly_sel;
    logic [DLY_W-1:0] dly_val;
    logic             alu_use;
    logic             prng_use;
    logic             alu_done;
    logic             alu_zero;
    logic             flush;
    logic             alu_start;
    logic             prng_start;
    logic             busy;
    logic             retire;
    logic [OPR_W-1:0] retire_opr;
    logic             jmp_req;
    logic [PRF_W-1:0] stall_cnt;

    modport master (
        output dec_vld, opr_typ, dly_sel, dly_val, alu_use, prng_use,
               alu_done, alu_zero, flush,
        input  dec_rdy, alu_start, prng_start, busy, retire, retire_opr,
               jmp_req, stall_cnt
    );

    modport slave (
        input  dec_vld, opr_typ, dly_sel, dly_val, alu_use, prng_use,
               alu_done, alu_zero, flush,
        output dec_rdy, alu_start, prng_start, busy, retire, retire_opr,
               jmp_req, stall_cnt
    );

endinterface

// File: rtl/exe_dly_sequencer_dly_down_counter.sv
// Loadable down-counter that tracks the remaining wait of the instruction
// in flight; it stops at zero rather than wrapping.
module dly_down_counter #(
    parameter int DLY_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DLY_W-1:0] load_val,
    input  logic             dec,
    output logic             term,
    output logic             zero
);
    localparam logic [DLY_W-1:0] CNT_ZERO = {DLY_W{1'b0}};
    localparam logic [DLY_W-1:0] CNT_ONE  = {{(DLY_W-1){1'b0}}, 1'b1};

    logic [DLY_W-1:0] cnt_q;
    logic [DLY_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != CNT_ZERO)) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term = (cnt_q == CNT_ONE);
    assign zero = (cnt_q == CNT_ZERO);

endmodule

// File: rtl/exe_dly_sequencer.sv
// Execution delay sequencer: strobes the selected unit for one decoded
// instruction, holds for its delay or until early ALU completion, then retires.
module exe_dly_sequencer
    import exe_dly_sequencer_pkg::*;
#(
    parameter int OPR_W = OPR_W_DEF,
    parameter int DLY_W = DLY_W_DEF,
    parameter int PRF_W = PRF_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    exe_dly_sequencer_if.slave bus
);
    localparam logic [PRF_W-1:0] STALL_ZERO = {PRF_W{1'b0}};
    localparam logic [PRF_W-1:0] STALL_ONE  = {{(PRF_W-1){1'b0}}, 1'b1};
    localparam logic [PRF_W-1:0] STALL_MAX  = {PRF_W{1'b1}};
    localparam logic [OPR_W-1:0] OPR_ZERO   = {OPR_W{1'b0}};
    localparam logic [OPR_W-1:0] OPR_JMP_C  = OPR_W'(OPR_JMP);
    localparam logic [OPR_W-1:0] OPR_JRE_C  = OPR_W'(OPR_JRE);
    localparam logic [DLY_W-1:0] DLY_ZERO   = {DLY_W{1'b0}};

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [OPR_W-1:0] opr_q;
    logic [OPR_W-1:0] opr_d;
    logic             alu_use_q;
    logic             alu_use_d;
    logic             prng_use_q;
    logic             prng_use_d;
    logic [DLY_W-1:0] eff_dly_q;
    logic [DLY_W-1:0] eff_dly_d;

    logic             alu_start_q;
    logic             alu_start_d;
    logic             prng_start_q;
    logic             prng_start_d;
    logic             retire_q;
    logic             retire_d;
    logic [OPR_W-1:0] retire_opr_q;
    logic [OPR_W-1:0] retire_opr_d;
    logic             jmp_req_q;
    logic             jmp_req_d;
    logic [PRF_W-1:0] stall_cnt_q;
    logic [PRF_W-1:0] stall_cnt_d;

    logic             cnt_term_s;
    logic             cnt_zero_s;
    logic             early_done_s;
    logic             jmp_hit_s;

    dly_down_counter #(
        .DLY_W (DLY_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state_q == ST_ISSUE),
        .load_val (eff_dly_q),
        .dec      (state_q == ST_WAIT),
        .term     (cnt_term_s),
        .zero     (cnt_zero_s)
    );

    assign early_done_s = bus.alu_done & alu_use_q;
    assign jmp_hit_s    = (opr_q == OPR_JMP_C) | ((opr_q == OPR_JRE_C) & bus.alu_zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            opr_q      <= OPR_ZERO;
            alu_use_q  <= 1'b0;
            prng_use_q <= 1'b0;
            eff_dly_q  <= DLY_ZERO;
        end else begin
            state_q    <= state_d;
            opr_q      <= opr_d;
            alu_use_q  <= alu_use_d;
            prng_use_q <= prng_use_d;
            eff_dly_q  <= eff_dly_d;
        end
    end

    // Zero in WAIT cannot occur from a legal load; treating it as terminal keeps the FSM from hanging.
    always_comb begin
        state_d    = state_q;
        opr_d      = opr_q;
        alu_use_d  = alu_use_q;
        prng_use_d = prng_use_q;
        eff_dly_d  = eff_dly_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.dec_vld) begin
                    state_d    = ST_ISSUE;
                    opr_d      = bus.opr_typ;
                    alu_use_d  = bus.alu_use;
                    prng_use_d = bus.prng_use;
                    eff_dly_d  = bus.dly_sel ? bus.dly_val : DLY_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (eff_dly_q == DLY_ZERO) begin
                    state_d = ST_RETIRE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_term_s || cnt_zero_s || early_done_s) begin
                    state_d = ST_RETIRE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RETIRE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        alu_start_d  = 1'b0;
        prng_start_d = 1'b0;
        retire_d     = 1'b0;
        retire_opr_d = OPR_ZERO;
        jmp_req_d    = 1'b0;
        stall_cnt_d  = stall_cnt_q;
        case (state_q)
            ST_ISSUE: begin
                alu_start_d  = alu_use_q & ~bus.flush;
                prng_start_d = prng_use_q & ~bus.flush;
            end
            ST_WAIT: begin
                if (stall_cnt_q != STALL_MAX) begin
                    stall_cnt_d = stall_cnt_q + STALL_ONE;
                end else begin
                    stall_cnt_d = stall_cnt_q;
                end
            end
            ST_RETIRE: begin
                retire_d     = 1'b1;
                retire_opr_d = opr_q;
                jmp_req_d    = jmp_hit_s;
            end
            default: begin
                stall_cnt_d = stall_cnt_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_start_q  <= 1'b0;
            prng_start_q <= 1'b0;
            retire_q     <= 1'b0;
            retire_opr_q <= OPR_ZERO;
            jmp_req_q    <= 1'b0;
            stall_cnt_q  <= STALL_ZERO;
        end else begin
            alu_start_q  <= alu_start_d;
            prng_start_q <= prng_start_d;
            retire_q     <= retire_d;
            retire_opr_q <= retire_opr_d;
            jmp_req_q    <= jmp_req_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.dec_rdy    = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.alu_start  = alu_start_q;
    assign bus.prng_start = prng_start_q;
    assign bus.retire     = retire_q;
    assign bus.retire_opr = retire_opr_q;
    assign bus.jmp_req    = jmp_req_q;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_exe_dly_sequencer.sv
// Bench for exe_dly_sequencer: an instruction-age reference model checked
// every cycle, directed cases with hand-computed latencies, random traffic.
module tb_exe_dly_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    exe_dly_sequencer_if bus_if ();

    exe_dly_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    // Reference model: an instruction is tracked by its age since acceptance and
    // the age at which it retires (delay + 2, pulled in by a valid alu_done).
    bit         m_busy = 1'b0;
    int         m_age = 0;
    int         m_ret = 0;
    logic [4:0] m_opr = 5'd0;
    bit         m_alu = 1'b0;
    bit         m_prng = 1'b0;
    int         m_stall = 0;
    bit         e_as = 1'b0, e_ps = 1'b0, e_ret = 1'b0, e_jmp = 1'b0;
    logic [4:0] e_opr = 5'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_age = 0; m_ret = 0; m_opr = 5'd0; m_alu = 1'b0; m_prng = 1'b0;
            m_stall = 0; e_as = 1'b0; e_ps = 1'b0; e_ret = 1'b0; e_jmp = 1'b0; e_opr = 5'd0;
        end else begin
            e_as = 1'b0; e_ps = 1'b0; e_ret = 1'b0; e_jmp = 1'b0; e_opr = 5'd0;
            if (!m_busy) begin
                if (bus_if.dec_vld) begin
                    m_busy = 1'b1;
                    m_age  = 1;
                    m_opr  = bus_if.opr_typ;
                    m_alu  = bus_if.alu_use;
                    m_prng = bus_if.prng_use;
                    m_ret  = (bus_if.dly_sel ? int'(bus_if.dly_val) : 0) + 2;
                end
            end else if (m_age == m_ret) begin
                e_ret  = 1'b1;
                e_opr  = m_opr;
                e_jmp  = (m_opr == 5'd16) || ((m_opr == 5'd17) && bus_if.alu_zero);
                m_busy = 1'b0;
            end else begin
                if (m_age >= 2 && m_stall < 65535) m_stall++;
                if (bus_if.flush) begin
                    m_busy = 1'b0;
                end else begin
                    if (m_age == 1) begin
                        e_as = m_alu;
                        e_ps = m_prng;
                    end else if (bus_if.alu_done && m_alu) begin
                        m_ret = m_age + 1;
                    end
                    m_age++;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("dec_rdy",    int'(bus_if.dec_rdy),    int'(!m_busy));
        chk("busy",       int'(bus_if.busy),       int'(m_busy));
        chk("alu_start",  int'(bus_if.alu_start),  int'(e_as));
        chk("prng_start", int'(bus_if.prng_start), int'(e_ps));
        chk("retire",     int'(bus_if.retire),     int'(e_ret));
        chk("retire_opr", int'(bus_if.retire_opr), int'(e_opr));
        chk("jmp_req",    int'(bus_if.jmp_req),    int'(e_jmp));
        chk("stall_cnt",  int'(bus_if.stall_cnt),  m_stall);
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Results of the last run_one call, indexed by k = edges since the handshake edge.
    int         r_rc;
    int         r_dstall;
    logic       r_jmp;
    logic [4:0] r_opr;
    logic       r_as1;
    logic       r_ps1;
    logic       r_rdy [0:15];

    task automatic drive_idle_inputs();
        bus_if.dec_vld  = 1'b0;
        bus_if.opr_typ  = 5'd0;
        bus_if.dly_sel  = 1'b0;
        bus_if.dly_val  = 8'd0;
        bus_if.alu_use  = 1'b0;
        bus_if.prng_use = 1'b0;
        bus_if.alu_done = 1'b0;
        bus_if.alu_zero = 1'b0;
        bus_if.flush    = 1'b0;
    endtask

    task automatic run_one(input logic [4:0] opr, input logic dsel, input logic [7:0] dval,
                           input logic au, input logic pu, input logic zero, input int done_at,
                           input int flush_at, input int span, input logic hold);
        logic [15:0] s0;
        s0 = bus_if.stall_cnt;
        bus_if.opr_typ  = opr;
        bus_if.dly_sel  = dsel;
        bus_if.dly_val  = dval;
        bus_if.alu_use  = au;
        bus_if.prng_use = pu;
        bus_if.alu_zero = zero;
        bus_if.dec_vld  = 1'b1;
        @(negedge clk);
        if (!hold) bus_if.dec_vld = 1'b0;
        r_rc = -1; r_dstall = -1; r_jmp = 1'b0; r_opr = 5'd0; r_as1 = 1'b0; r_ps1 = 1'b0;
        for (int i = 0; i < 16; i++) r_rdy[i] = 1'b0;
        for (int k = 0; k < span; k++) begin
            if (k < 16) r_rdy[k] = bus_if.dec_rdy;
            if (k == 1) begin
                r_as1 = bus_if.alu_start;
                r_ps1 = bus_if.prng_start;
            end
            if (bus_if.retire && r_rc < 0) begin
                r_rc     = k;
                r_jmp    = bus_if.jmp_req;
                r_opr    = bus_if.retire_opr;
                r_dstall = int'(bus_if.stall_cnt) - int'(s0);
            end
            bus_if.alu_done = (k == done_at - 1);
            bus_if.flush    = (k == flush_at - 1);
            @(negedge clk);
        end
        bus_if.dec_vld  = 1'b0;
        bus_if.alu_done = 1'b0;
        bus_if.flush    = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (bus_if.dec_rdy) break;
            @(negedge clk);
        end
        chk("idle_reached", int'(bus_if.dec_rdy), 1);
    endtask

    initial begin
        drive_idle_inputs();
        repeat (3) @(negedge clk);
        chk("rst_dec_rdy",   int'(bus_if.dec_rdy),   1);
        chk("rst_busy",      int'(bus_if.busy),      0);
        chk("rst_retire",    int'(bus_if.retire),    0);
        chk("rst_alu_start", int'(bus_if.alu_start), 0);
        chk("rst_stall",     int'(bus_if.stall_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD, delay 4, no early completion
        run_one(5'd2, 1'b1, 8'd4, 1'b1, 1'b0, 1'b0, -1, -1, 10, 1'b0);
        chk("add_rdy0", int'(r_rdy[0]), 0);
        chk("add_as1", int'(r_as1), 1);
        chk("add_ps1", int'(r_ps1), 0);
        chk("add_rc", r_rc, 6);
        chk("add_opr", int'(r_opr), 2);
        chk("add_jmp", int'(r_jmp), 0);
        chk("add_stall", r_dstall, 4);
        wait_idle();

        // MUL, delay 255, early completion at cycle 10
        run_one(5'd4, 1'b1, 8'd255, 1'b1, 1'b0, 1'b0, 10, -1, 15, 1'b0);
        chk("mul_rc", r_rc, 11);
        chk("mul_stall", r_dstall, 9);
        wait_idle();

        // Same without alu_use: alu_done ignored
        run_one(5'd4, 1'b1, 8'd255, 1'b0, 1'b1, 1'b0, 10, -1, 262, 1'b0);
        chk("mul_nalu_rc", r_rc, 257);
        chk("mul_nalu_stall", r_dstall, 255);
        chk("mul_nalu_ps1", int'(r_ps1), 1);
        wait_idle();

        run_one(5'd17, 1'b1, 8'd7, 1'b1, 1'b0, 1'b1, -1, -1, 12, 1'b0);
        chk("jre_z1_rc", r_rc, 9);
        chk("jre_z1_jmp", int'(r_jmp), 1);
        wait_idle();
        run_one(5'd17, 1'b1, 8'd7, 1'b1, 1'b0, 1'b0, -1, -1, 12, 1'b0);
        chk("jre_z0_jmp", int'(r_jmp), 0);
        wait_idle();
        run_one(5'd16, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, -1, -1, 8, 1'b0);
        chk("jmp_rc", r_rc, 5);
        chk("jmp_jmp", int'(r_jmp), 1);
        chk("jmp_opr", int'(r_opr), 16);
        wait_idle();

        // MOV with delay field invalid, dec_vld held for back-to-back
        run_one(5'd1, 1'b0, 8'd200, 1'b0, 1'b0, 1'b0, -1, -1, 6, 1'b1);
        chk("mov_rc", r_rc, 2);
        chk("mov_as1", int'(r_as1), 0);
        chk("mov_rdy0", int'(r_rdy[0]), 0);
        chk("mov_rdy1", int'(r_rdy[1]), 0);
        chk("mov_rdy2", int'(r_rdy[2]), 1);
        chk("mov_rdy3", int'(r_rdy[3]), 0);
        wait_idle();

        run_one(5'd3, 1'b1, 8'd20, 1'b1, 1'b0, 1'b0, -1, 5, 30, 1'b0);
        chk("flw_rc", r_rc, -1);
        chk("flw_rdy4", int'(r_rdy[4]), 0);
        chk("flw_rdy5", int'(r_rdy[5]), 1);
        wait_idle();
        run_one(5'd3, 1'b1, 8'd5, 1'b1, 1'b1, 1'b0, -1, 1, 10, 1'b0);
        chk("fli_as1", int'(r_as1), 0);
        chk("fli_ps1", int'(r_ps1), 0);
        chk("fli_rdy1", int'(r_rdy[1]), 1);
        chk("fli_rc", r_rc, -1);
        wait_idle();

        // Async reset in the middle of a wait
        run_one(5'd5, 1'b1, 8'd50, 1'b1, 1'b0, 1'b0, -1, -1, 6, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_dec_rdy", int'(bus_if.dec_rdy), 1);
        chk("mrst_busy", int'(bus_if.busy), 0);
        chk("mrst_retire", int'(bus_if.retire), 0);
        chk("mrst_stall", int'(bus_if.stall_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_one(5'd2, 1'b1, 8'd4, 1'b1, 1'b0, 1'b0, -1, -1, 10, 1'b0);
        chk("post_rst_rc", r_rc, 6);
        chk("post_rst_stall", r_dstall, 4);
        wait_idle();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            bus_if.dec_vld  = ($urandom_range(0, 1) == 0);
            case ($urandom_range(0, 3))
                0:       bus_if.opr_typ = 5'd16;
                1:       bus_if.opr_typ = 5'd17;
                default: bus_if.opr_typ = 5'($urandom_range(0, 31));
            endcase
            bus_if.dly_sel  = ($urandom_range(0, 3) != 0);
            bus_if.dly_val  = 8'($urandom_range(0, 12));
            bus_if.alu_use  = ($urandom_range(0, 1) == 0);
            bus_if.prng_use = ($urandom_range(0, 1) == 0);
            bus_if.alu_done = ($urandom_range(0, 4) == 0);
            bus_if.alu_zero = ($urandom_range(0, 1) == 0);
            bus_if.flush    = ($urandom_range(0, 19) == 0);
            @(negedge clk);
        end
        drive_idle_inputs();
        wait_idle();

        // Long back-to-back maximum delays to drive stall_cnt into saturation
        bus_if.opr_typ = 5'd9;
        bus_if.dly_sel = 1'b1;
        bus_if.dly_val = 8'd255;
        bus_if.dec_vld = 1'b1;
        repeat (66600) @(negedge clk);
        chk("stall_sat", int'(bus_if.stall_cnt), 65535);
        repeat (300) @(negedge clk);
        chk("stall_sat_hold", int'(bus_if.stall_cnt), 65535);
        drive_idle_inputs();
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
